// File: rtl/msp430_mem_defs.sv
// -----------------------------------------------------------------------------
// msp430_mem_defs
// Shared definitions for the MSP430 data-memory slice: access FSM encoding,
// read/write and byte/word flag values, and the byte-lane enable helper.
// -----------------------------------------------------------------------------
package msp430_mem_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  localparam logic BW_WORD  = 1'b0;
  localparam logic BW_BYTE  = 1'b1;

  // Little-endian lanes: even byte address is [7:0], odd byte address is [15:8].
  function automatic logic [1:0] byte_en(input logic bw, input logic a0);
    if (bw == BW_WORD) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_array.sv
// -----------------------------------------------------------------------------
// ram_array
// DEPTH_WORDS x 16 storage with a byte-enabled write port and a registered
// (synchronous) read port.
//   clk      : clock
//   we, be   : write enable, per-byte lane enables (be[0] -> [7:0])
//   wr_idx   : write word index
//   wr_data  : write data (both lanes presented; be selects)
//   re       : read enable, rd_data updates on the next rising edge
//   rd_idx   : read word index
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module ram_array #(
  parameter int DEPTH_WORDS = 512,
  parameter int AW          = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [1:0]    be,
  input  logic [AW-1:0] wr_idx,
  input  logic [15:0]   wr_data,
  input  logic          re,
  input  logic [AW-1:0] rd_idx,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [DEPTH_WORDS];

  // NOTE: storage has no reset on purpose; contents survive rst_n and the
  // array maps onto plain SRAM macros without a clear path.
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[0]) mem[wr_idx][7:0]  <= wr_data[7:0];
      if (be[1]) mem[wr_idx][15:8] <= wr_data[15:8];
    end
    if (re) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/ram_ws.sv
// -----------------------------------------------------------------------------
// ram_ws
// Wait-stated data RAM for the MSP430 memory stage with an address window,
// out-of-window error and a req/rdy handshake. Byte and word accesses,
// little-endian.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : access request, held high until rdy
//   ram_RW     : 1 = write, 0 = read
//   BW         : 1 = byte, 0 = word
//   ram_addr   : byte address
//   ram_Din    : write data (byte writes use [7:0])
//   ram_out    : read data, valid with rdy, held between reads
//   rdy        : one-cycle completion pulse
//   err        : pulses with rdy when the address missed the window
// -----------------------------------------------------------------------------
module ram_ws
  import msp430_mem_defs::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0200,
  parameter int          DEPTH_WORDS = 512,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        ram_RW,
  input  logic        BW,
  input  logic [15:0] ram_addr,
  input  logic [15:0] ram_Din,
  output logic [15:0] ram_out,
  output logic        rdy,
  output logic        err
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam int          TOP   = int'(BASE_ADDR) + 2 * DEPTH_WORDS;
  localparam logic [16:0] TOP17 = 17'(TOP);
  localparam logic [2:0]  WS3   = 3'(WAIT_STATES);

  if (TOP > 32'h0001_0000) begin : g_bad_window
    $error("ram_ws: window top exceeds 16'hFFFF");
  end
  if (DEPTH_WORDS < 2 || DEPTH_WORDS > 32768 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("ram_ws: DEPTH_WORDS must be a power of 2 in 2..32768");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 7) begin : g_bad_ws
    $error("ram_ws: WAIT_STATES must be 0..7");
  end

  function automatic logic in_window(input logic [15:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < TOP17);
  endfunction

  // Word index drops bit 0, which also forces word accesses even.
  function automatic logic [AW-1:0] idx_of(input logic [15:0] a);
    return AW'((a - BASE_ADDR) >> 1);
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   addr_q, din_q, ram_out_q;
  logic          rw_q, bw_q, hit_q;
  logic          capture;
  logic          rd_en;
  logic [AW-1:0] rd_idx;
  logic [15:0]   rd_data;
  logic [15:0]   read_fmt, resp_val;
  logic          wr_en;

  assign capture = (state_q == IDLE) && req;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_idx  = idx_of(addr_q);
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = 3'd1;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            // No wait states: read straight from the live inputs so the
            // data lands as the FSM enters RESP.
            state_d = RESP;
            rd_en   = (ram_RW == RW_READ) && in_window(ram_addr);
            rd_idx  = idx_of(ram_addr);
          end
        end
      end
      WAIT: begin
        if (cnt_q == WS3) begin
          state_d = RESP;
          rd_en   = (rw_q == RW_READ) && hit_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= 16'h0000;
      din_q     <= 16'h0000;
      rw_q      <= RW_READ;
      bw_q      <= BW_WORD;
      hit_q     <= 1'b0;
      ram_out_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q <= ram_addr;
        din_q  <= ram_Din;
        rw_q   <= ram_RW;
        bw_q   <= BW;
        hit_q  <= in_window(ram_addr);
      end
      if (state_q == RESP) ram_out_q <= resp_val;
    end
  end

  assign read_fmt = (bw_q == BW_BYTE)
                  ? {8'h00, (addr_q[0] ? rd_data[15:8] : rd_data[7:0])}
                  : rd_data;

  // Misses force zero; writes leave the previous read result visible.
  assign resp_val = !hit_q              ? 16'h0000 :
                    (rw_q == RW_READ)   ? read_fmt : ram_out_q;

  assign rdy     = (state_q == RESP);
  assign err     = rdy && !hit_q;
  assign ram_out = rdy ? resp_val : ram_out_q;

  // Commit happens on the edge that leaves RESP; a reset before it aborts.
  assign wr_en = rdy && (rw_q == RW_WRITE) && hit_q;

  ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .we     (wr_en),
    .be     (byte_en(bw_q, addr_q[0])),
    .wr_idx (idx_of(addr_q)),
    .wr_data((bw_q == BW_BYTE) ? {din_q[7:0], din_q[7:0]} : din_q),
    .re     (rd_en),
    .rd_idx (rd_idx),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_ram_ws.sv
// -----------------------------------------------------------------------------
// tb_ram_ws
// Two instances: d=0 (512 words, no wait states) and d=1 (64 words, three
// wait states). A word-array model of the memory predicts every response.
// -----------------------------------------------------------------------------
module tb_ram_ws;

  localparam logic [15:0] BASE = 16'h0200;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        req   [2];
  logic        rw    [2];
  logic        bw    [2];
  logic [15:0] addr  [2];
  logic [15:0] din   [2];
  logic [15:0] dout  [2];
  logic        rdy   [2];
  logic        err   [2];

  always #5 clk = ~clk;

  ram_ws #(.BASE_ADDR(BASE), .DEPTH_WORDS(512), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .ram_RW(rw[0]), .BW(bw[0]),
    .ram_addr(addr[0]), .ram_Din(din[0]), .ram_out(dout[0]),
    .rdy(rdy[0]), .err(err[0])
  );

  ram_ws #(.BASE_ADDR(BASE), .DEPTH_WORDS(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .ram_RW(rw[1]), .BW(bw[1]),
    .ram_addr(addr[1]), .ram_Din(din[1]), .ram_out(dout[1]),
    .rdy(rdy[1]), .err(err[1])
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem_m    [2][512];
  logic [15:0] last_out [2];

  function automatic int depth_of(input int d);
    return (d == 0) ? 512 : 64;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: decode the window with plain integers and apply the access.
  task automatic model(input int d, input bit w, input bit b, input logic [15:0] a,
                       input logic [15:0] dd, output logic [15:0] eo, output bit ee);
    int idx;
    logic [15:0] word;
    if (int'(a) < int'(BASE) || int'(a) >= int'(BASE) + 2 * depth_of(d)) begin
      eo = 16'h0000;
      ee = 1'b1;
    end else begin
      ee   = 1'b0;
      idx  = (int'(a) - int'(BASE)) / 2;
      word = mem_m[d][idx];
      if (w) begin
        if (!b)       word = dd;
        else if (a[0]) word[15:8] = dd[7:0];
        else          word[7:0]  = dd[7:0];
        mem_m[d][idx] = word;
        eo = last_out[d];
      end else begin
        eo = b ? {8'h00, (a[0] ? word[15:8] : word[7:0])} : word;
      end
    end
    last_out[d] = eo;
  endtask

  // Starts at a negedge. b2b: the DUT is in RESP from the previous access.
  // keep: leave req high on rdy so the next call chains back-to-back.
  task automatic access(input int d, input bit w, input bit b, input logic [15:0] a,
                        input logic [15:0] dd, input bit b2b, input bit keep);
    logic [15:0] eo;
    bit ee;
    int cyc;
    bit seen;
    string tg;
    tg = $sformatf("d%0d %s%s @%h", d, w ? "wr" : "rd", b ? "B" : "W", a);
    model(d, w, b, a, dd, eo, ee);
    req[d] = 1'b1; rw[d] = w; bw[d] = b; addr[d] = a; din[d] = dd;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (rdy[d]) seen = 1;
      else if (b2b ? (cyc >= 2) : (cyc >= 1)) begin
        // Inputs after capture must be ignored.
        rw[d] = 1'($urandom); bw[d] = 1'($urandom);
        addr[d] = 16'($urandom); din[d] = 16'($urandom);
      end
    end
    check({tg, " latency"}, cyc, ws_of(d) + 1 + int'(b2b));
    check({tg, " ram_out"}, dout[d], eo);
    check({tg, " err"}, err[d], ee);
    if (!keep) begin
      req[d] = 1'b0;
      @(negedge clk);
      check({tg, " rdy pulse"}, rdy[d], 1'b0);
      check({tg, " hold"}, dout[d], eo);
    end
  endtask

  task automatic rst_pulse(input int d, input string tg);
    rst_n[d] = 1'b0;
    #1;
    check({tg, " rdy"}, rdy[d], 1'b0);
    check({tg, " err"}, err[d], 1'b0);
    check({tg, " ram_out"}, dout[d], 16'h0000);
    req[d] = 1'b0;
    @(negedge clk);
    rst_n[d] = 1'b1;
    last_out[d] = 16'h0000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, v;
    bit b2b, keep;
    int r;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; rw[d] = 1'b0; bw[d] = 1'b0;
      addr[d] = 16'h0000; din[d] = 16'h0000; last_out[d] = 16'h0000;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset rdy", d), rdy[d], 1'b0);
      check($sformatf("d%0d reset err", d), err[d], 1'b0);
      check($sformatf("d%0d reset ram_out", d), dout[d], 16'h0000);
      rst_n[d] = 1'b1;
    end
    @(negedge clk);

    // Known contents everywhere so any later read is predictable.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < depth_of(d); i++)
        access(d, 1, 0, BASE + 16'(2 * i), 16'($urandom), 0, 0);

    // Word / byte basics, no wait states.
    access(0, 1, 0, 16'h0200, 16'hBEEF, 0, 0);
    access(0, 0, 0, 16'h0200, 16'h0000, 0, 0);
    check("d0 beef readback", dout[0], 16'hBEEF);
    access(0, 1, 1, 16'h0201, 16'hFF12, 0, 0);
    access(0, 0, 0, 16'h0200, 16'h0000, 0, 0);
    check("d0 byte merge", dout[0], 16'h12EF);
    access(0, 0, 1, 16'h0200, 16'h0000, 0, 0);
    check("d0 byte read lo", dout[0], 16'h00EF);
    access(0, 0, 1, 16'h0201, 16'h0000, 0, 0);

    // Wait states, back-to-back with req held, LSB ignored for words.
    access(1, 0, 0, 16'h0202, 16'h0000, 0, 1);
    access(1, 0, 0, 16'h0204, 16'h0000, 1, 0);
    access(1, 1, 0, 16'h0202, 16'hA5A5, 0, 0);
    access(1, 0, 0, 16'h0203, 16'h0000, 0, 0);
    check("d1 odd word read", dout[1], 16'hA5A5);

    // Window edges on both instances.
    for (int d = 0; d < 2; d++) begin
      access(d, 1, 0, 16'h0100, 16'h1234, 0, 0);
      access(d, 1, 0, BASE + 16'(2 * depth_of(d)), 16'h4321, 0, 0);
      access(d, 1, 1, 16'h01FF, 16'h0099, 0, 0);
      access(d, 0, 1, BASE + 16'(2 * depth_of(d) - 1), 16'h0000, 0, 0);
      access(d, 0, 0, 16'hFFFE, 16'h0000, 0, 0);
    end

    // Reset in the second wait cycle aborts the write.
    req[1] = 1'b1; rw[1] = 1'b1; bw[1] = 1'b0; addr[1] = 16'h0204; din[1] = 16'h5555;
    repeat (2) @(negedge clk);
    rst_pulse(1, "d1 reset in WAIT");
    access(1, 0, 0, 16'h0204, 16'h0000, 0, 0);

    // Reset while RESP is showing, before the commit edge.
    req[0] = 1'b1; rw[0] = 1'b1; bw[0] = 1'b0; addr[0] = 16'h0206; din[0] = 16'h5A5A;
    @(negedge clk);
    check("d0 resp before reset", rdy[0], 1'b1);
    rst_pulse(0, "d0 reset in RESP");
    access(0, 0, 0, 16'h0206, 16'h0000, 0, 0);

    // Randomised traffic, biased to a few words to exercise read-after-write.
    for (int d = 0; d < 2; d++) begin
      b2b = 0;
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = 16'($urandom_range(0, int'(BASE) - 1));
        else if (r == 1) a = BASE + 16'(2 * depth_of(d)) + 16'($urandom_range(0, 200));
        else             a = BASE + 16'($urandom_range(0, 15));
        v = 16'($urandom);
        keep = (n != 79) && ($urandom_range(0, 2) == 0);
        access(d, 1'($urandom), 1'($urandom), a, v, b2b, keep);
        b2b = keep;
      end
    end

    // Full sweep: nothing outside the model's writes may have changed.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < depth_of(d); i++)
        access(d, 0, 0, BASE + 16'(2 * i), 16'h0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
